// File: rtl/dense_param_stream.sv
// Host parameter port for the dense layer weight RAMs. It either dumps one RAM
// to the host over a valid/ready stream or loads host data into it. It drives
// one RAM read/write port while the layer is idle.
module dense_param_stream #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DENSE_DATA_N = 6,
  parameter int N_LEN        = 16,
  parameter int HID_DIM      = 64,
  parameter int CHAR_NUM     = 96,
  parameter int DATA_WIDTH   = DENSE_DATA_N * N_LEN,
  parameter int DATA_DEPTH   = HID_DIM * CHAR_NUM / DENSE_DATA_N
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_dump,
  input  logic                  start_load,
  output logic                  busy,
  output logic                  done,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  ram_load,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DATA_DEPTH);
  localparam logic [CW-1:0] LAST_C  = CW'(DATA_DEPTH - 1);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic [1:0] {IDLE, DUMP, LOAD, DONE} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
  logic [CW-1:0]         wr_cnt_q, wr_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic [DATA_WIDTH-1:0] fifo_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            fifo_cnt_q, fifo_cnt_d;
  logic                  push, pop, rd_en, accept;
  logic [1:0]            level;

  // Next-state, datapath and output decode for the transfer FSM.
  always_comb begin
    state_d    = state_q;
    rd_cnt_d   = rd_cnt_q;
    tx_cnt_d   = tx_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    inflight_d = 1'b0;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    push       = 1'b0;
    pop        = 1'b0;
    rd_en      = 1'b0;
    accept     = 1'b0;
    level      = '0;
    busy       = 1'b0;
    done       = 1'b0;
    m_valid    = 1'b0;
    m_data     = '0;
    s_ready    = 1'b0;
    ram_raddr  = '0;
    ram_load   = 1'b0;
    ram_waddr  = '0;
    ram_wdata  = '0;
    case (state_q)
      IDLE: begin
        if (start_dump)      state_d = DUMP;
        else if (start_load) state_d = LOAD;
      end
      DUMP: begin
        busy    = 1'b1;
        m_valid = (fifo_cnt_q != 2'd0);
        m_data  = m_valid ? fifo_q[rd_ptr_q] : '0;
        pop     = m_valid & m_ready;
        push    = inflight_q;
        // The slot freed by this cycle's pop is credited to the issue check;
        // without it a read every cycle is impossible and a bubble appears
        // every other beat. The word it fetches lands after the pop, so the
        // two-entry FIFO still cannot overflow.
        level   = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
        rd_en   = (rd_cnt_q < DEPTH_C) && (level < 2'd2);
        if (rd_en) begin
          ram_raddr = rd_cnt_q[ADDR_WIDTH-1:0];
          rd_cnt_d  = rd_cnt_q + ONE_C;
        end
        inflight_d = rd_en;
        if (push) begin
          fifo_d[wr_ptr_q] = ram_rdata;
          wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
          rd_ptr_d = ~rd_ptr_q;
          tx_cnt_d = tx_cnt_q + ONE_C;
          if (tx_cnt_q == LAST_C) state_d = DONE;
        end
        fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
      end
      LOAD: begin
        busy    = 1'b1;
        s_ready = (wr_cnt_q < DEPTH_C);
        accept  = s_valid & s_ready;
        if (accept) begin
          ram_load  = 1'b1;
          ram_waddr = wr_cnt_q[ADDR_WIDTH-1:0];
          ram_wdata = s_data;
          wr_cnt_d  = wr_cnt_q + ONE_C;
          if (wr_cnt_q == LAST_C) state_d = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_d    = IDLE;
        rd_cnt_d   = '0;
        tx_cnt_d   = '0;
        wr_cnt_d   = '0;
        wr_ptr_d   = 1'b0;
        rd_ptr_d   = 1'b0;
        fifo_cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and FIFO registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      inflight_q <= 1'b0;
      fifo_q     <= '{default: '0};
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      inflight_q <= inflight_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

endmodule

// File: tb/tb_dense_param_stream.sv
// Directed bench for dense_param_stream: a depth-4 instance with a RAM model,
// a depth-1 instance, and a depth-15 instance that reaches the last address.
module tb_dense_param_stream;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam logic [0:19] RP = 20'b1001011010_1111111111;
  localparam logic [0:7]  VP = 8'b1011_0011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic          a_start_dump = 1'b0, a_start_load = 1'b0, a_busy, a_done;
  logic          a_m_valid, a_m_ready = 1'b0, a_s_valid = 1'b0, a_s_ready, a_load;
  logic [DW-1:0] a_m_data, a_s_data = '0, a_rdata, a_wdata;
  logic [AW-1:0] a_raddr, a_waddr;

  logic          b_start_dump = 1'b0, b_busy, b_done, b_m_valid, b_m_ready = 1'b1, b_s_ready, b_load;
  logic [DW-1:0] b_m_data, b_rdata, b_wdata;
  logic [AW-1:0] b_raddr, b_waddr;

  logic          c_start_dump = 1'b0, c_busy, c_done, c_m_valid, c_m_ready = 1'b1, c_s_ready, c_load;
  logic [DW-1:0] c_m_data, c_rdata, c_wdata;
  logic [AW-1:0] c_raddr, c_waddr;

  logic [DW-1:0] mem_a [16];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always @(posedge clk) begin
    a_rdata <= mem_a[a_raddr];
    if (a_load) mem_a[a_waddr] <= a_wdata;
    else if (pre_we) mem_a[pre_addr] <= pre_data;
  end
  always @(posedge clk) b_rdata <= 8'h5A ^ {4'h0, b_raddr};
  always @(posedge clk) c_rdata <= 8'h80 + {4'h0, c_raddr};

  dense_param_stream #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_DEPTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .start_dump(a_start_dump), .start_load(a_start_load),
    .busy(a_busy), .done(a_done), .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data),
    .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data), .ram_raddr(a_raddr),
    .ram_rdata(a_rdata), .ram_load(a_load), .ram_waddr(a_waddr), .ram_wdata(a_wdata));

  dense_param_stream #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_DEPTH(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start_dump(b_start_dump), .start_load(1'b0),
    .busy(b_busy), .done(b_done), .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
    .s_valid(1'b0), .s_ready(b_s_ready), .s_data('0), .ram_raddr(b_raddr),
    .ram_rdata(b_rdata), .ram_load(b_load), .ram_waddr(b_waddr), .ram_wdata(b_wdata));

  dense_param_stream #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_DEPTH(15)) u_c (
    .clk(clk), .rst_n(rst_n), .start_dump(c_start_dump), .start_load(1'b0),
    .busy(c_busy), .done(c_done), .m_valid(c_m_valid), .m_ready(c_m_ready), .m_data(c_m_data),
    .s_valid(1'b0), .s_ready(c_s_ready), .s_data('0), .ram_raddr(c_raddr),
    .ram_rdata(c_rdata), .ram_load(c_load), .ram_waddr(c_waddr), .ram_wdata(c_wdata));

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_cmp++;
    if ({a_busy, a_done, a_m_valid, a_s_ready, a_load} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags_a: got %b want 00000", {a_busy, a_done, a_m_valid, a_s_ready, a_load});
    end
    n_cmp++;
    if ({a_m_data, a_raddr, a_waddr, a_wdata} !== '0) begin
      n_err++; $display("FAIL reset_buses_a: got %h want 0", {a_m_data, a_raddr, a_waddr, a_wdata});
    end
    n_cmp++;
    if ({b_busy, b_done, b_m_valid, b_s_ready, b_load, c_busy, c_done, c_m_valid, c_s_ready, c_load} !== 10'b0) begin
      n_err++; $display("FAIL reset_flags_bc: got %b want 0", {b_busy, b_done, b_m_valid, b_s_ready, b_load, c_busy, c_done, c_m_valid, c_s_ready, c_load});
    end
    n_cmp++;
    if ({b_m_data, b_raddr, b_waddr, b_wdata, c_m_data, c_raddr, c_waddr, c_wdata} !== '0) begin
      n_err++; $display("FAIL reset_buses_bc: got %h want 0", {b_m_data, b_raddr, b_waddr, b_wdata, c_m_data, c_raddr, c_waddr, c_wdata});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic preload_a();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      pre_we = 1'b1; pre_addr = AW'(i); pre_data = DW'(8'h11 * (i + 1));
    end
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic test_dump_timing();
    logic [DW-1:0] w;
    @(posedge clk); #1;
    a_m_ready = 1'b1; a_start_dump = 1'b1;
    @(posedge clk); #1;
    a_start_dump = 1'b0;
    n_cmp++;
    if (a_busy !== 1'b1 || a_raddr !== '0) begin
      n_err++; $display("FAIL dump_first_read: busy=%b raddr=%0d want busy=1 raddr=0", a_busy, a_raddr);
    end
    for (int c = 0; c < 8; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      n_cmp++;
      if (a_m_valid !== (c >= 2 && c <= 5)) begin
        n_err++; $display("FAIL dump_valid_c%0d: got %b want %b", c, a_m_valid, (c >= 2 && c <= 5));
      end
      if (c >= 2 && c <= 5) begin
        w = DW'(8'h11 * (c - 1));
        n_cmp++;
        if (a_m_data !== w) begin
          n_err++; $display("FAIL dump_data_c%0d: got %h want %h", c, a_m_data, w);
        end
      end
      n_cmp++;
      if (a_done !== (c == 6) || a_busy !== (c < 6) || a_load !== 1'b0) begin
        n_err++; $display("FAIL dump_ctrl_c%0d: done=%b busy=%b load=%b want done=%b busy=%b load=0",
                          c, a_done, a_busy, a_load, (c == 6), (c < 6));
      end
    end
  endtask

  task automatic run_dump_a(input logic [4*DW-1:0] exp_words, input logic stall, input string tag);
    int got = 0;
    int dones = 0;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_d = '0;
    @(posedge clk); #1;
    a_start_dump = 1'b1;
    a_m_ready = stall ? RP[0] : 1'b1;
    @(posedge clk); #1;
    a_start_dump = 1'b0;
    for (int k = 0; k < 40 && dones == 0; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      a_m_ready = stall ? RP[k % 20] : 1'b1;
      n_cmp++;
      if (a_load !== 1'b0 || $isunknown(a_raddr) || a_raddr > AW'(3)) begin
        n_err++; $display("FAIL %s_port_k%0d: load=%b raddr=%0d want load=0 raddr<=3", tag, k, a_load, a_raddr);
      end
      if (prev_stall) begin
        n_cmp++;
        if (a_m_valid !== 1'b1 || a_m_data !== prev_d) begin
          n_err++; $display("FAIL %s_hold_k%0d: valid=%b data=%h want valid=1 data=%h", tag, k, a_m_valid, a_m_data, prev_d);
        end
      end
      if (a_m_valid === 1'b1 && a_m_ready) begin
        n_cmp++;
        if (got >= 4) begin
          n_err++; $display("FAIL %s_extra_beat: got beat %0d data %h want only 4 beats", tag, got, a_m_data);
        end else if (a_m_data !== exp_words[got*DW +: DW]) begin
          n_err++; $display("FAIL %s_beat%0d: got %h want %h", tag, got, a_m_data, exp_words[got*DW +: DW]);
        end
        got++;
      end
      prev_stall = (a_m_valid === 1'b1) && !a_m_ready;
      prev_d = a_m_data;
      if (a_done === 1'b1) dones++;
    end
    n_cmp++;
    if (got != 4) begin n_err++; $display("FAIL %s_beat_count: got %0d want 4", tag, got); end
    n_cmp++;
    if (dones != 1) begin n_err++; $display("FAIL %s_done_seen: got %0d want 1", tag, dones); end
    @(posedge clk); #1;
    n_cmp++;
    if (a_done !== 1'b0 || a_busy !== 1'b0) begin
      n_err++; $display("FAIL %s_after_done: done=%b busy=%b want 0 0", tag, a_done, a_busy);
    end
    a_m_ready = 1'b0;
  endtask

  task automatic run_load_a(input logic [DW-1:0] base, input string tag);
    int acc = 0;
    logic [DW-1:0] ev;
    @(posedge clk); #1;
    a_start_load = 1'b1;
    @(posedge clk); #1;
    a_start_load = 1'b0;
    for (int k = 0; k < 30 && acc < 4; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      ev = DW'(int'(base) + acc);
      a_s_valid = VP[k % 8];
      a_s_data = a_s_valid ? ev : 8'hEE;
      #1;
      n_cmp++;
      if (a_s_ready !== 1'b1 || a_load !== a_s_valid) begin
        n_err++; $display("FAIL %s_hs_k%0d: ready=%b load=%b want ready=1 load=%b", tag, k, a_s_ready, a_load, a_s_valid);
      end
      if (a_s_valid) begin
        n_cmp++;
        if (a_waddr !== AW'(acc) || a_wdata !== ev) begin
          n_err++; $display("FAIL %s_write%0d: addr=%0d data=%h want addr=%0d data=%h", tag, acc, a_waddr, a_wdata, acc, ev);
        end
        acc++;
      end else begin
        n_cmp++;
        if ({a_waddr, a_wdata} !== '0) begin
          n_err++; $display("FAIL %s_idle_bus_k%0d: got %h want 0", tag, k, {a_waddr, a_wdata});
        end
      end
    end
    @(posedge clk); #1;
    a_s_valid = 1'b1; a_s_data = 8'hEE;
    #1;
    n_cmp++;
    if (a_done !== 1'b1 || a_s_ready !== 1'b0 || a_load !== 1'b0 || a_busy !== 1'b0) begin
      n_err++; $display("FAIL %s_end: done=%b ready=%b load=%b busy=%b want 1 0 0 0", tag, a_done, a_s_ready, a_load, a_busy);
    end
    @(posedge clk); #1;
    a_s_valid = 1'b0;
    #1;
    n_cmp++;
    if (a_done !== 1'b0 || a_busy !== 1'b0) begin
      n_err++; $display("FAIL %s_done_once: done=%b busy=%b want 0 0", tag, a_done, a_busy);
    end
  endtask

  task automatic test_both_starts();
    int got = 0;
    int dones = 0;
    logic [4*DW-1:0] ew = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    @(posedge clk); #1;
    a_start_dump = 1'b1; a_start_load = 1'b1; a_m_ready = 1'b1;
    a_s_valid = 1'b1; a_s_data = 8'h77;
    @(posedge clk); #1;
    a_start_dump = 1'b0;
    for (int k = 0; k < 20 && dones == 0; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      n_cmp++;
      if (a_s_ready !== 1'b0 || a_load !== 1'b0 || (k == 0 && a_busy !== 1'b1)) begin
        n_err++; $display("FAIL both_k%0d: ready=%b load=%b busy=%b want 0 0 busy", k, a_s_ready, a_load, a_busy);
      end
      if (a_m_valid === 1'b1) begin
        n_cmp++;
        if (got >= 4) begin
          n_err++; $display("FAIL both_extra_beat: data %h want only 4 beats", a_m_data);
        end else if (a_m_data !== ew[got*DW +: DW]) begin
          n_err++; $display("FAIL both_beat%0d: got %h want %h", got, a_m_data, ew[got*DW +: DW]);
        end
        got++;
      end
      if (a_done === 1'b1) begin
        dones++; a_start_load = 1'b0; a_s_valid = 1'b0;
      end
    end
    a_start_load = 1'b0; a_s_valid = 1'b0;
    n_cmp++;
    if (got != 4 || dones != 1) begin
      n_err++; $display("FAIL both_totals: beats=%0d dones=%0d want 4 1", got, dones);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (a_busy !== 1'b0) begin n_err++; $display("FAIL both_idle: busy=%b want 0", a_busy); end
  endtask

  task automatic test_reset_mid_load();
    @(posedge clk); #1;
    a_start_load = 1'b1;
    @(posedge clk); #1;
    a_start_load = 1'b0; a_s_valid = 1'b1; a_s_data = 8'h5A;
    @(posedge clk); #1;
    a_s_data = 8'h5B;
    @(posedge clk); #1;
    a_s_data = 8'h5C;
    #1;
    n_cmp++;
    if (a_load !== 1'b1 || a_waddr !== AW'(2)) begin
      n_err++; $display("FAIL rst_pre: load=%b addr=%0d want 1 2", a_load, a_waddr);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({a_busy, a_done, a_m_valid, a_s_ready, a_load} !== 5'b0 || {a_m_data, a_raddr, a_waddr, a_wdata} !== '0) begin
      n_err++; $display("FAIL rst_async: flags=%b buses=%h want 0", {a_busy, a_done, a_m_valid, a_s_ready, a_load},
                        {a_m_data, a_raddr, a_waddr, a_wdata});
    end
    a_s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_dump_a({8'hA3, 8'hA2, 8'h5B, 8'h5A}, 1'b0, "rst_dump");
    run_load_a(8'hC0, "reload");
    run_dump_a({8'hC3, 8'hC2, 8'hC1, 8'hC0}, 1'b1, "reload_dump");
  endtask

  task automatic test_depth_one();
    @(posedge clk); #1;
    b_start_dump = 1'b1;
    @(posedge clk); #1;
    b_start_dump = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      n_cmp++;
      if (b_m_valid !== (k == 2) || b_done !== (k == 3) || b_raddr !== '0) begin
        n_err++; $display("FAIL d1_k%0d: valid=%b done=%b raddr=%0d want %b %b 0", k, b_m_valid, b_done, b_raddr, (k == 2), (k == 3));
      end
      if (k == 2) begin
        n_cmp++;
        if (b_m_data !== 8'h5A) begin n_err++; $display("FAIL d1_data: got %h want 5a", b_m_data); end
      end
    end
  endtask

  task automatic test_depth_max();
    int got = 0;
    int done_k = -1;
    logic [DW-1:0] ev;
    @(posedge clk); #1;
    c_start_dump = 1'b1;
    @(posedge clk); #1;
    c_start_dump = 1'b0;
    for (int k = 0; k < 60 && done_k < 0; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      n_cmp++;
      if ($isunknown(c_raddr) || c_raddr > AW'(14)) begin
        n_err++; $display("FAIL dmax_raddr_k%0d: got %0d want <=14", k, c_raddr);
      end
      if (c_m_valid === 1'b1) begin
        ev = DW'(8'h80 + got);
        n_cmp++;
        if (got >= 15 || c_m_data !== ev) begin
          n_err++; $display("FAIL dmax_beat%0d: got %h want %h", got, c_m_data, ev);
        end
        got++;
      end
      if (c_done === 1'b1) done_k = k;
    end
    n_cmp++;
    if (got != 15 || done_k != 17) begin
      n_err++; $display("FAIL dmax_totals: beats=%0d done_cycle=%0d want 15 17", got, done_k);
    end
  endtask

  initial begin
    test_reset();
    preload_a();
    test_dump_timing();
    run_dump_a({8'h44, 8'h33, 8'h22, 8'h11}, 1'b1, "backpressure");
    run_load_a(8'hA0, "load");
    run_dump_a({8'hA3, 8'hA2, 8'hA1, 8'hA0}, 1'b0, "load_dump");
    test_both_starts();
    test_reset_mid_load();
    test_depth_one();
    test_depth_max();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
